// File: rtl/lfsr_rng_gen.sv
// Purpose: pseudo-random byte source; free-running 16-bit Galois LFSR, byte captured after STEPS decorrelation clocks.
// Latency: Req sampled at edge N -> Valid high after edge N+STEPS (plus one clock per reject with RNG_RANGE_EN).
// Backpressure: captured byte held with Valid until Ack; Req ignored while Busy (not queued).
//
// Optional feature macro: RNG_RANGE_EN -- rejection sampling so that Value never exceeds RANGE_MAX.
//
// Ports:
//   Clk        rising-edge system clock
//   Reset_n    asynchronous active-low reset
//   Seed_load  load Seed into the LFSR this edge (overrides everything, returns to IDLE)
//   Seed       16-bit seed; zero is replaced by SEED so the LFSR never locks up
//   Req        request a new byte (only looked at in IDLE)
//   Ack        consumer took Value (only looked at in PRESENT)
//   Value      captured byte, stable while Valid=1
//   Valid      Value is new and not yet acknowledged
//   Busy       high in GEN and PRESENT

module lfsr_rng_gen #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned STEPS     = 8,
    parameter logic [7:0]  RANGE_MAX = 8'hFF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Seed_load,
    input  logic [15:0] Seed,
    input  logic        Req,
    input  logic        Ack,
    output logic [7:0]  Value,
    output logic        Valid,
    output logic        Busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GEN     = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // Counter is loaded with STEPS-1 on acceptance; the capture happens on the
    // edge where it reads zero, giving exactly STEPS edges of latency.
    localparam logic [7:0] CNT_INIT = 8'(STEPS - 1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  value_q, value_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic [15:0] lfsr_next;
    logic        capture_ok;

    // Galois right-shift form, taps 16,14,13,11 (mask B400): maximal period 65535.
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

`ifdef RNG_RANGE_EN
    // Reject out-of-range bytes; the FSM stays at cnt==0 and retries next edge
    // against a fresh LFSR value, keeping the accepted values uniform.
    assign capture_ok = (lfsr_q[7:0] <= RANGE_MAX);
`else
    assign capture_ok = 1'b1;
    // RANGE_MAX only matters when rejection sampling is compiled in.
    logic unused_range_max;
    assign unused_range_max = ^RANGE_MAX;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = valid_q;
        lfsr_d  = lfsr_next;

        if (Seed_load) begin
            // Reseed wins over everything; Value keeps its old contents.
            lfsr_d  = (Seed == 16'h0000) ? SEED : Seed;
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Req) begin
                        state_d = ST_GEN;
                        cnt_d   = CNT_INIT;
                    end
                end
                ST_GEN: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (capture_ok) begin
                        // Capture the pre-step register contents.
                        value_d = lfsr_q[7:0];
                        valid_d = 1'b1;
                        state_d = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (Ack) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= 8'd0;
            value_q <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign Value = value_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;

endmodule
